// File: rtl/rtds_pkg.sv
// Shared definitions for the RTDS receive path: word width, default bank depth
// and the deframer state encoding.
package rtds_pkg;

  localparam int RTDS_WORD_W    = 32;
  localparam int RTDS_MAX_WORDS = 64;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RECV    = 2'd1,
    S_DISCARD = 2'd2
  } rtds_state_t;

endpackage

// File: rtl/rtds_word_bank.sv
// Double-buffered packet store: simple dual-port RAM, one write port and a
// registered read port. The MSB of each address selects the half.
module rtds_word_bank
  import rtds_pkg::*;
#(
  parameter int AW = 7
) (
  input  logic                   clk,
  input  logic                   srst,
  input  logic                   wr_en,
  input  logic [AW-1:0]          wr_addr,
  input  logic [RTDS_WORD_W-1:0] wr_data,
  input  logic [AW-1:0]          rd_addr,
  output logic [RTDS_WORD_W-1:0] rd_data
);

  logic [RTDS_WORD_W-1:0] mem [0:(1<<AW)-1];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Contents are never cleared; only the output register resets.
  always_ff @(posedge clk) begin
    if (srst) begin
      rd_data <= '0;
    end else begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/rtds_rx_deframer.sv
// RTDS packet deframer on the Aurora RX stream: length check, double-buffered
// word bank, stats and delayed reply trigger. Optional macro: RX_TIMESTAMP_EN.
module rtds_rx_deframer
  import rtds_pkg::*;
#(
  parameter int MAX_WORDS = RTDS_MAX_WORDS,
  parameter int ADDR_W    = 6
) (
  input  logic                   user_clk,
  input  logic                   sys_reset,
  input  logic                   s_axis_tvalid,
  input  logic [RTDS_WORD_W-1:0] s_axis_tdata,
  input  logic                   s_axis_tlast,
  input  logic [ADDR_W:0]        cfg_exp_words,
  input  logic [15:0]            cfg_tx_delay,
  input  logic [ADDR_W-1:0]      rd_addr,
  output logic [RTDS_WORD_W-1:0] rd_data,
  output logic                   pkt_done,
  output logic                   tx_trigger,
  output logic                   busy,
  output logic [31:0]            stat_pkt_cnt,
  output logic [15:0]            stat_err_cnt,
  output logic [ADDR_W:0]        stat_last_len,
  output logic [31:0]            stat_last_ts
);

  localparam int LEN_W = ADDR_W + 1;
  localparam logic [LEN_W-1:0] CNT_MAX = LEN_W'(MAX_WORDS);
  localparam logic [LEN_W-1:0] OVF_LEN = LEN_W'(MAX_WORDS + 1);
  localparam logic [LEN_W-1:0] CNT_ONE = LEN_W'(1);

  rtds_state_t      state_reg, state_next;
  logic [LEN_W-1:0] cnt_reg, cnt_next;
  logic             bank_sel_reg;
  logic             wr_en;
  logic             eval_en;
  logic             eval_good;
  logic [LEN_W-1:0] eval_len;

  logic             pkt_done_reg;
  logic [31:0]      pkt_cnt_reg;
  logic [15:0]      err_cnt_reg;
  logic [LEN_W-1:0] last_len_reg;
  logic             dly_active_reg;
  logic [15:0]      dly_cnt_reg;

  always_ff @(posedge user_clk) begin
    if (sys_reset) begin
      state_reg <= S_IDLE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // cnt_reg holds the number of beats already taken, i.e. the index of the current beat.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    wr_en      = 1'b0;
    eval_en    = 1'b0;
    eval_good  = 1'b0;
    eval_len   = cnt_reg + CNT_ONE;
    if (s_axis_tvalid) begin
      case (state_reg)
        S_IDLE: begin
          wr_en    = 1'b1;
          eval_len = CNT_ONE;
          if (s_axis_tlast) begin
            eval_en   = 1'b1;
            eval_good = (cfg_exp_words == CNT_ONE);
          end else begin
            state_next = S_RECV;
            cnt_next   = CNT_ONE;
          end
        end
        S_RECV: begin
          wr_en = (cnt_reg != CNT_MAX);
          if (s_axis_tlast) begin
            eval_en    = 1'b1;
            eval_good  = (cnt_reg != CNT_MAX) && (eval_len == cfg_exp_words);
            state_next = S_IDLE;
            cnt_next   = '0;
          end else if (cnt_reg == CNT_MAX) begin
            state_next = S_DISCARD;
          end else begin
            cnt_next = cnt_reg + CNT_ONE;
          end
        end
        S_DISCARD: begin
          eval_len = OVF_LEN;
          if (s_axis_tlast) begin
            eval_en    = 1'b1;
            state_next = S_IDLE;
            cnt_next   = '0;
          end
        end
        default: begin
          state_next = S_IDLE;
          cnt_next   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge user_clk) begin
    if (sys_reset) begin
      bank_sel_reg <= 1'b0;
      pkt_done_reg <= 1'b0;
      pkt_cnt_reg  <= '0;
      err_cnt_reg  <= '0;
      last_len_reg <= '0;
    end else begin
      pkt_done_reg <= eval_en && eval_good;
      if (eval_en) begin
        last_len_reg <= eval_len;
        if (eval_good) begin
          bank_sel_reg <= ~bank_sel_reg;
          pkt_cnt_reg  <= pkt_cnt_reg + 32'd1;
        end else if (err_cnt_reg != 16'hFFFF) begin
          err_cnt_reg <= err_cnt_reg + 16'd1;
        end
      end
    end
  end

  // A fresh pkt_done always reloads, so a pending trigger for an older packet is dropped.
  always_ff @(posedge user_clk) begin
    if (sys_reset) begin
      dly_active_reg <= 1'b0;
      dly_cnt_reg    <= '0;
    end else if (pkt_done_reg) begin
      dly_active_reg <= (cfg_tx_delay != 16'd0);
      dly_cnt_reg    <= cfg_tx_delay;
    end else if (dly_active_reg) begin
      if (dly_cnt_reg == 16'd1) begin
        dly_active_reg <= 1'b0;
      end
      dly_cnt_reg <= dly_cnt_reg - 16'd1;
    end
  end

  assign tx_trigger    = pkt_done_reg ? (cfg_tx_delay == 16'd0)
                                      : (dly_active_reg && (dly_cnt_reg == 16'd1));
  assign pkt_done      = pkt_done_reg;
  assign busy          = (state_reg != S_IDLE);
  assign stat_pkt_cnt  = pkt_cnt_reg;
  assign stat_err_cnt  = err_cnt_reg;
  assign stat_last_len = last_len_reg;

`ifdef RX_TIMESTAMP_EN
  logic [31:0] ts_reg;
  logic [31:0] last_ts_reg;

  always_ff @(posedge user_clk) begin
    if (sys_reset) begin
      ts_reg      <= '0;
      last_ts_reg <= '0;
    end else begin
      ts_reg <= ts_reg + 32'd1;
      if (eval_en && eval_good) begin
        last_ts_reg <= ts_reg;
      end
    end
  end

  assign stat_last_ts = last_ts_reg;
`else
  assign stat_last_ts = 32'h0;
`endif

  rtds_word_bank #(
    .AW (ADDR_W + 1)
  ) u_bank (
    .clk     (user_clk),
    .srst    (sys_reset),
    .wr_en   (wr_en),
    .wr_addr ({~bank_sel_reg, cnt_reg[ADDR_W-1:0]}),
    .wr_data (s_axis_tdata),
    .rd_addr ({bank_sel_reg, rd_addr}),
    .rd_data (rd_data)
  );

endmodule

// File: tb/tb_rtds_rx_deframer.sv
// Directed bench for rtds_rx_deframer: packet table plus hand-written trigger,
// reset and timestamp sequences.
module tb_rtds_rx_deframer;

  localparam int ADDR_W = 6;

  logic              user_clk = 1'b0;
  logic              sys_reset = 1'b1;
  logic              s_axis_tvalid = 1'b0;
  logic [31:0]       s_axis_tdata = '0;
  logic              s_axis_tlast = 1'b0;
  logic [ADDR_W:0]   cfg_exp_words = 7'd4;
  logic [15:0]       cfg_tx_delay = 16'd0;
  logic [ADDR_W-1:0] rd_addr = '0;
  logic [31:0]       rd_data;
  logic              pkt_done;
  logic              tx_trigger;
  logic              busy;
  logic [31:0]       stat_pkt_cnt;
  logic [15:0]       stat_err_cnt;
  logic [ADDR_W:0]   stat_last_len;
  logic [31:0]       stat_last_ts;

  rtds_rx_deframer #(.MAX_WORDS(64), .ADDR_W(ADDR_W)) dut (
    .user_clk      (user_clk),
    .sys_reset     (sys_reset),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tlast  (s_axis_tlast),
    .cfg_exp_words (cfg_exp_words),
    .cfg_tx_delay  (cfg_tx_delay),
    .rd_addr       (rd_addr),
    .rd_data       (rd_data),
    .pkt_done      (pkt_done),
    .tx_trigger    (tx_trigger),
    .busy          (busy),
    .stat_pkt_cnt  (stat_pkt_cnt),
    .stat_err_cnt  (stat_err_cnt),
    .stat_last_len (stat_last_len),
    .stat_last_ts  (stat_last_ts)
  );

  always #5 user_clk = ~user_clk;

  typedef struct {
    int          nbeats;
    int          exp_words;
    bit          good;
    int          len;
    logic [31:0] base;
  } vec_t;

  vec_t vecs [8];
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int trig_seen = 0;
  int trig_cyc = 0;
  int exp_pkt = 0;
  int exp_err = 0;
  logic [31:0] pub_base = '0;
  int pub_len = 0;
  int p2_cyc = 0;
  logic [31:0] exp_ts;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge user_clk);
    #1;
    cyc++;
    if (tx_trigger) begin
      trig_seen++;
      trig_cyc = cyc;
    end
  endtask

  task automatic beat(input logic [31:0] d, input logic last);
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = d;
    s_axis_tlast  = last;
    step();
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  task automatic send_pkt(input logic [31:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      beat(base + 32'(i), (i == n - 1));
    end
  endtask

  task automatic check_bank(input string name, input logic [31:0] base, input int len);
    for (int a = 0; a < len; a++) begin
      rd_addr = 6'(a);
      step();
      chk(name, rd_data, base + 32'(a));
    end
  endtask

  initial begin
    vecs[0] = '{nbeats: 4,  exp_words: 4,  good: 1'b1, len: 4,  base: 32'hA000_0000};
    vecs[1] = '{nbeats: 3,  exp_words: 4,  good: 1'b0, len: 3,  base: 32'hB100_0000};
    vecs[2] = '{nbeats: 70, exp_words: 64, good: 1'b0, len: 65, base: 32'hC200_0000};
    vecs[3] = '{nbeats: 64, exp_words: 64, good: 1'b1, len: 64, base: 32'hD300_0000};
    vecs[4] = '{nbeats: 1,  exp_words: 1,  good: 1'b1, len: 1,  base: 32'hE400_0000};
    vecs[5] = '{nbeats: 1,  exp_words: 2,  good: 1'b0, len: 1,  base: 32'hF500_0000};
    vecs[6] = '{nbeats: 65, exp_words: 64, good: 1'b0, len: 65, base: 32'h1600_0000};
    vecs[7] = '{nbeats: 2,  exp_words: 2,  good: 1'b1, len: 2,  base: 32'h2700_0000};

    repeat (3) step();
    chk("rst_pkt_done", 32'(pkt_done), 32'd0);
    chk("rst_tx_trigger", 32'(tx_trigger), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_pkt_cnt", stat_pkt_cnt, 32'd0);
    chk("rst_err_cnt", 32'(stat_err_cnt), 32'd0);
    chk("rst_last_len", 32'(stat_last_len), 32'd0);
    chk("rst_last_ts", stat_last_ts, 32'd0);
    chk("rst_rd_data", rd_data, 32'd0);
    sys_reset = 1'b0;
    step();

    // Packet table with zero trigger delay: tx_trigger follows pkt_done.
    for (int v = 0; v < 8; v++) begin
      cfg_exp_words = 7'(vecs[v].exp_words);
      for (int i = 0; i < vecs[v].nbeats - 1; i++) begin
        beat(vecs[v].base + 32'(i), 1'b0);
      end
      if (vecs[v].nbeats > 1) chk($sformatf("v%0d_busy", v), 32'(busy), 32'd1);
      beat(vecs[v].base + 32'(vecs[v].nbeats - 1), 1'b1);
      if (vecs[v].good) begin
        exp_pkt++;
        pub_base = vecs[v].base;
        pub_len  = vecs[v].len;
      end else begin
        exp_err++;
      end
      chk($sformatf("v%0d_pkt_done", v), 32'(pkt_done), 32'(vecs[v].good));
      chk($sformatf("v%0d_tx_trigger", v), 32'(tx_trigger), 32'(vecs[v].good));
      chk($sformatf("v%0d_pkt_cnt", v), stat_pkt_cnt, 32'(exp_pkt));
      chk($sformatf("v%0d_err_cnt", v), 32'(stat_err_cnt), 32'(exp_err));
      chk($sformatf("v%0d_last_len", v), 32'(stat_last_len), 32'(vecs[v].len));
      chk($sformatf("v%0d_busy_after", v), 32'(busy), 32'd0);
      rd_addr = '0;
      step();
      chk($sformatf("v%0d_pulse_end", v), 32'(pkt_done), 32'd0);
      check_bank($sformatf("v%0d_bank", v), pub_base, pub_len);
    end

    // Two good packets five cycles apart with delay 10: one trigger after the second.
    cfg_exp_words = 7'd4;
    cfg_tx_delay  = 16'd10;
    trig_seen = 0;
    send_pkt(32'h3800_0000, 4);
    chk("dly_pkt1_done", 32'(pkt_done), 32'd1);
    step();
    send_pkt(32'h3900_0000, 4);
    chk("dly_pkt2_done", 32'(pkt_done), 32'd1);
    p2_cyc = cyc;
    repeat (15) step();
    exp_pkt += 2;
    chk("dly_trig_count", 32'(trig_seen), 32'd1);
    chk("dly_trig_offset", 32'(trig_cyc - p2_cyc), 32'd10);
    chk("dly_pkt_cnt", stat_pkt_cnt, 32'(exp_pkt));

    // Reset in the middle of a packet, then a clean packet.
    cfg_tx_delay = 16'd0;
    beat(32'h4A00_0000, 1'b0);
    beat(32'h4A00_0001, 1'b0);
    sys_reset = 1'b1;
    beat(32'h4A00_0002, 1'b0);
    sys_reset = 1'b0;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_pkt_cnt", stat_pkt_cnt, 32'd0);
    chk("mid_rst_err_cnt", 32'(stat_err_cnt), 32'd0);
    send_pkt(32'h5B00_0000, 4);
    chk("post_rst_pkt_done", 32'(pkt_done), 32'd1);
    chk("post_rst_pkt_cnt", stat_pkt_cnt, 32'd1);
    chk("post_rst_err_cnt", 32'(stat_err_cnt), 32'd0);
    chk("post_rst_last_len", 32'(stat_last_len), 32'd4);
    check_bank("post_rst_bank", 32'h5B00_0000, 4);

    // Timestamp: tlast presented in cycle 100 after reset release.
    sys_reset = 1'b1;
    repeat (2) step();
    sys_reset = 1'b0;
    repeat (100) step();
    cfg_exp_words = 7'd1;
    beat(32'h6C00_0000, 1'b1);
`ifdef RX_TIMESTAMP_EN
    exp_ts = 32'd100;
`else
    exp_ts = 32'd0;
`endif
    chk("ts_pkt_done", 32'(pkt_done), 32'd1);
    chk("ts_last_ts", stat_last_ts, exp_ts);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
